mac_operand_feeder: RTL

- Source-side sequencer for the mac_array operand interface. It drives start, valid_in and the a/b lanes, and captures dot_out.
- Holds two small operand buffers (activation and weight), loaded through a simple write port.
- On a command, it streams a window of beats into the MAC array, waits the MAC latency, and returns the dot product on a ready/valid result port.
- Sits between the buffer/DMA layer and mac_array.

---
 rtl/mac_pkg.sv | 33 +++
 rtl/mac_operand_buf.sv | 25 ++
 rtl/mac_operand_feeder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC operand feeder: state encoding,
// lane/dot widths, and lane pack/unpack helpers for packed operand words.
package mac_pkg;

  localparam int LANE_W    = 8;
  localparam int DOT_W     = 36;
  localparam int MAX_LANES = 16;
  localparam int MAX_FLAT  = MAX_LANES * LANE_W;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    DRAIN,
    RESP
  } feeder_state_t;

  // Narrower words are zero-extended into MAX_FLAT by the caller.
  function automatic logic signed [LANE_W-1:0] lane_of(input logic [MAX_FLAT-1:0] flat,
                                                      input int idx);
    return flat[idx*LANE_W +: LANE_W];
  endfunction

  function automatic logic [MAX_FLAT-1:0] with_lane(input logic [MAX_FLAT-1:0] flat,
                                                   input int idx,
                                                   input logic signed [LANE_W-1:0] val);
    logic [MAX_FLAT-1:0] res;
    res = flat;
    res[idx*LANE_W +: LANE_W] = val;
    return res;
  endfunction

endpackage

// File: rtl/mac_operand_buf.sv
// DEPTH-entry operand register file: one synchronous write port and one
// combinational read port. Contents are intentionally not reset.
module mac_operand_buf
  import mac_pkg::*;
#(
  parameter int NUM_MACS = 4,
  parameter int DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [NUM_MACS*LANE_W-1:0]   wr_data,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [NUM_MACS*LANE_W-1:0]   rd_data
);

  logic [NUM_MACS*LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_operand_feeder.sv
// Source-side sequencer for mac_array: buffers operands, streams a window of
// beats, waits out the MAC latency and returns the dot product.
// Optional: MAC_FEEDER_SATURATE_EN saturates the result and adds sat_flag.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int NUM_MACS = 4,
  parameter int DEPTH    = 16,
  parameter int MAC_LAT  = 2,
  parameter int RES_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_sel,
  input  logic [$clog2(DEPTH)-1:0]      wr_addr,
  input  logic [NUM_MACS*8-1:0]         wr_data,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(DEPTH)-1:0]      cmd_base,
  input  logic [$clog2(DEPTH):0]        cmd_len,
  output logic                          start,
  output logic                          valid_in,
  output logic [NUM_MACS*8-1:0]         a_flat,
  output logic [NUM_MACS*8-1:0]         b_flat,
  input  logic [35:0]                   dot_in,
  output logic                          busy,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [RES_W-1:0]              result_data
`ifdef MAC_FEEDER_SATURATE_EN
  ,
  output logic                          sat_flag
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = NUM_MACS * LANE_W;
  localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  feeder_state_t   state, state_n;
  logic [AW-1:0]   ptr_q, ptr_n;
  logic [LW-1:0]   len_q, len_n;
  logic [LW-1:0]   cnt_q, cnt_n;
  logic [CW-1:0]   drain_q, drain_n;
  logic            capture;
  logic            wr_act, wr_wgt;
  logic [FW-1:0]   act_rd, wgt_rd;

`ifdef MAC_FEEDER_SATURATE_EN
  localparam logic signed [DOT_W-1:0] SAT_MAX = DOT_W'((64'sd1 <<< (RES_W-1)) - 64'sd1);
  localparam logic signed [DOT_W-1:0] SAT_MIN = -SAT_MAX - 1;

  function automatic logic sat_clip(input logic signed [DOT_W-1:0] d);
    return (d > SAT_MAX) || (d < SAT_MIN);
  endfunction

  function automatic logic [RES_W-1:0] shape_dot(input logic signed [DOT_W-1:0] d);
    if (d > SAT_MAX)      return SAT_MAX[RES_W-1:0];
    else if (d < SAT_MIN) return SAT_MIN[RES_W-1:0];
    else                  return d[RES_W-1:0];
  endfunction
`else
  function automatic logic [RES_W-1:0] shape_dot(input logic signed [DOT_W-1:0] d);
    return d[RES_W-1:0];
  endfunction
`endif

  // Buffers only accept writes while idle so a running window never changes.
  assign wr_act = wr_en && (state == IDLE) && !wr_sel;
  assign wr_wgt = wr_en && (state == IDLE) &&  wr_sel;

  mac_operand_buf #(.NUM_MACS(NUM_MACS), .DEPTH(DEPTH)) u_act_buf (
    .clk     (clk),
    .wr_en   (wr_act),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ptr_q),
    .rd_data (act_rd)
  );

  mac_operand_buf #(.NUM_MACS(NUM_MACS), .DEPTH(DEPTH)) u_wgt_buf (
    .clk     (clk),
    .wr_en   (wr_wgt),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ptr_q),
    .rd_data (wgt_rd)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    drain_n = drain_q;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n = START;
          ptr_n   = cmd_base;
          len_n   = (cmd_len > LW'(DEPTH)) ? LW'(DEPTH) : cmd_len;
          cnt_n   = '0;
          drain_n = '0;
        end
      end
      START:  state_n = (len_q != '0) ? STREAM : DRAIN;
      STREAM: if (cnt_q == len_q) state_n = DRAIN;
      DRAIN: begin
        if (drain_q == CW'(MAC_LAT - 1)) begin
          state_n = RESP;
          capture = 1'b1;
        end else begin
          drain_n = drain_q + 1'b1;
        end
      end
      RESP:    if (result_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A beat is issued on every cycle whose next state is STREAM; the
    // pointer wraps modulo DEPTH through its natural width.
    if (state_n == STREAM) begin
      ptr_n = ptr_q + 1'b1;
      cnt_n = cnt_q + 1'b1;
    end
  end

  // ---- registered outputs: everything visible to mac_array and the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      drain_q      <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      start        <= 1'b0;
      valid_in     <= 1'b0;
      a_flat       <= '0;
      b_flat       <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
`ifdef MAC_FEEDER_SATURATE_EN
      sat_flag     <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      ptr_q        <= ptr_n;
      len_q        <= len_n;
      cnt_q        <= cnt_n;
      drain_q      <= drain_n;
      cmd_ready    <= (state_n == IDLE);
      busy         <= (state_n != IDLE);
      start        <= (state_n == START);
      valid_in     <= (state_n == STREAM);
      a_flat       <= (state_n == STREAM) ? act_rd : '0;
      b_flat       <= (state_n == STREAM) ? wgt_rd : '0;
      result_valid <= (state_n == RESP);
      if (capture) result_data <= shape_dot($signed(dot_in));
`ifdef MAC_FEEDER_SATURATE_EN
      if (capture)               sat_flag <= sat_clip($signed(dot_in));
      else if (state_n != RESP)  sat_flag <= 1'b0;
`endif
    end
  end

endmodule
